// File: rtl/uc_multicycle_exc.sv
// Multicycle main control FSM for the 32-bit MIPS-subset datapath: wait-stated
// memory, mult/div start/done handshake and three vectored precise exceptions.
module uc_multicycle_exc #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MEM_WAIT   = 1,
    parameter int VEC_OPCODE = 253,
    parameter int VEC_OVF    = 254,
    parameter int VEC_DIV0   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] b_value,
    input  logic              overflow,
    input  logic              md_done,
    output logic              pc_write,
    output logic              pc_write_cond,
    output logic              ir_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              reg_write,
    output logic              ab_write,
    output logic              alu_out_write,
    output logic              epc_write,
    output logic              cause_write,
    output logic              init_mult,
    output logic              init_div,
    output logic              hi_write,
    output logic              lo_write,
    output logic [1:0]        pc_source,
    output logic [1:0]        iord,
    output logic [1:0]        reg_dst,
    output logic [1:0]        mem_to_reg,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [2:0]        alu_op,
    output logic [1:0]        branch_op,
    output logic [1:0]        int_cause,
    output logic [ADDR_W-1:0] exc_vector
);

    localparam logic [4:0] RST      = 5'd0;
    localparam logic [4:0] FETCH    = 5'd1;
    localparam logic [4:0] DECODE   = 5'd2;
    localparam logic [4:0] EXEC_R   = 5'd3;
    localparam logic [4:0] EXEC_I   = 5'd4;
    localparam logic [4:0] WB       = 5'd5;
    localparam logic [4:0] BRANCH   = 5'd6;
    localparam logic [4:0] JUMP     = 5'd7;
    localparam logic [4:0] JREG     = 5'd8;
    localparam logic [4:0] ADDR     = 5'd9;
    localparam logic [4:0] MEM_RD   = 5'd10;
    localparam logic [4:0] MEM_WR   = 5'd11;
    localparam logic [4:0] MD_START = 5'd12;
    localparam logic [4:0] MD_WAIT  = 5'd13;
    localparam logic [4:0] EXC0     = 5'd14;
    localparam logic [4:0] EXC_RD   = 5'd15;
    localparam logic [4:0] EXC_LD   = 5'd16;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLE   = 6'h06;
    localparam logic [5:0] OP_BGT   = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_JR     = 6'h08;
    localparam logic [5:0] F_MFHI   = 6'h10;
    localparam logic [5:0] F_MFLO   = 6'h12;
    localparam logic [5:0] F_MULT   = 6'h18;
    localparam logic [5:0] F_DIV    = 6'h1a;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_AND    = 6'h24;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    logic [4:0] state, nextState;
    logic [2:0] waitCnt;
    logic [5:0] opReg, fnReg;
    logic [1:0] cause, nextCause;
    logic       loadCause;
    logic [4:0] decNext;
    logic       memDone, counting;
    logic       isR, isAdd, isSub, isAddi, isDiv, isLw, isJal, isMfx;
    logic [ADDR_W-1:0] excVec;

    assign memDone  = (waitCnt == WAIT_LAST);
    assign counting = (state == FETCH) || (state == MEM_RD) || (state == EXC_RD);

    // Instruction class from the IR as seen during DECODE; EXC0 marks undefined.
    always_comb begin
        decNext = EXC0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_SUB, F_AND: decNext = EXEC_R;
                    F_MULT, F_DIV:       decNext = MD_START;
                    F_MFHI, F_MFLO:      decNext = WB;
                    F_JR:                decNext = JREG;
                    default:             decNext = EXC0;
                endcase
            end
            OP_ADDI, OP_ADDIU:               decNext = EXEC_I;
            OP_BEQ, OP_BNE, OP_BLE, OP_BGT:  decNext = BRANCH;
            OP_J, OP_JAL:                    decNext = JUMP;
            OP_LW, OP_SW:                    decNext = ADDR;
            default:                         decNext = EXC0;
        endcase
    end

    assign isR    = (opReg == OP_RTYPE);
    assign isAdd  = isR && (fnReg == F_ADD);
    assign isSub  = isR && (fnReg == F_SUB);
    assign isDiv  = isR && (fnReg == F_DIV);
    assign isMfx  = isR && ((fnReg == F_MFHI) || (fnReg == F_MFLO));
    assign isAddi = (opReg == OP_ADDI);
    assign isLw   = (opReg == OP_LW);
    assign isJal  = (opReg == OP_JAL);

    always_comb begin
        nextState = RST;
        nextCause = 2'd0;
        loadCause = 1'b0;
        case (state)
            RST:      nextState = FETCH;
            FETCH:    nextState = memDone ? DECODE : FETCH;
            DECODE: begin
                nextState = decNext;
                loadCause = (decNext == EXC0);
                nextCause = 2'd0;
            end
            EXEC_R: begin
                loadCause = overflow && (isAdd || isSub);
                nextCause = 2'd1;
                nextState = loadCause ? EXC0 : WB;
            end
            EXEC_I: begin
                loadCause = overflow && isAddi;
                nextCause = 2'd1;
                nextState = loadCause ? EXC0 : WB;
            end
            ADDR:     nextState = isLw ? MEM_RD : MEM_WR;
            MEM_RD:   nextState = memDone ? WB : MEM_RD;
            MD_START: begin
                loadCause = isDiv && (b_value == '0);
                nextCause = 2'd2;
                nextState = loadCause ? EXC0 : MD_WAIT;
            end
            MD_WAIT:  nextState = md_done ? FETCH : MD_WAIT;
            EXC0:     nextState = EXC_RD;
            EXC_RD:   nextState = memDone ? EXC_LD : EXC_RD;
            WB, BRANCH, JUMP, JREG, MEM_WR, EXC_LD: nextState = FETCH;
            default:  nextState = RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= RST;
            waitCnt <= '0;
            opReg   <= '0;
            fnReg   <= '0;
            cause   <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= (counting && !memDone) ? waitCnt + 3'd1 : 3'd0;
            if (state == DECODE) begin
                opReg <= opcode;
                fnReg <= funct;
            end
            if (loadCause) cause <= nextCause;
        end
    end

    always_comb begin
        case (cause)
            2'd0:    excVec = ADDR_W'(VEC_OPCODE);
            2'd1:    excVec = ADDR_W'(VEC_OVF);
            default: excVec = ADDR_W'(VEC_DIV0);
        endcase
    end

    // Moore decode of state/latched IR; only init_div (b_value) and the
    // hi/lo writes (md_done) look at live inputs. reset=0 silences everything.
    always_comb begin
        pc_write = 1'b0; pc_write_cond = 1'b0; ir_write = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
        ab_write = 1'b0; alu_out_write = 1'b0; epc_write = 1'b0;
        cause_write = 1'b0; init_mult = 1'b0; init_div = 1'b0;
        hi_write = 1'b0; lo_write = 1'b0;
        pc_source = 2'd0; iord = 2'd0; reg_dst = 2'd0; mem_to_reg = 2'd0;
        alu_src_a = 1'b0; alu_src_b = 2'd0; alu_op = 3'd0; branch_op = 2'd0;
        int_cause = 2'd0; exc_vector = '0;
        if (reset) begin
            case (state)
                FETCH: begin
                    mem_read = 1'b1;
                    if (memDone) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        alu_src_b = 2'd1;
                    end
                end
                DECODE: begin
                    ab_write      = 1'b1;
                    alu_out_write = 1'b1;
                    alu_src_b     = 2'd3;
                end
                EXEC_R: begin
                    alu_out_write = 1'b1;
                    alu_src_a     = 1'b1;
                    alu_op        = isSub ? 3'd1 : (fnReg == F_AND) ? 3'd2 : 3'd0;
                end
                EXEC_I, ADDR: begin
                    alu_out_write = 1'b1;
                    alu_src_a     = 1'b1;
                    alu_src_b     = 2'd2;
                end
                WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = isR ? 2'd1 : 2'd0;
                    mem_to_reg = isLw ? 2'd1 : isMfx ? 2'd3 : 2'd0;
                end
                BRANCH: begin
                    pc_write_cond = 1'b1;
                    pc_source     = 2'd1;
                    alu_src_a     = 1'b1;
                    alu_op        = 3'd1;
                    branch_op     = opReg[1:0];
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'd2;
                    if (isJal) begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'd2;
                        mem_to_reg = 2'd2;
                    end
                end
                JREG: begin
                    pc_write  = 1'b1;
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                end
                MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 2'd1;
                end
                MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 2'd1;
                end
                MD_START: begin
                    init_mult = !isDiv;
                    init_div  = isDiv && (b_value != '0);
                end
                MD_WAIT: begin
                    hi_write = md_done;
                    lo_write = md_done;
                end
                EXC0: begin
                    epc_write   = 1'b1;
                    cause_write = 1'b1;
                    alu_src_b   = 2'd1;
                    alu_op      = 3'd1;
                    int_cause   = cause;
                    exc_vector  = excVec;
                end
                EXC_RD: begin
                    mem_read   = 1'b1;
                    iord       = 2'd2;
                    int_cause  = cause;
                    exc_vector = excVec;
                end
                EXC_LD: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'd3;
                    int_cause  = cause;
                    exc_vector = excVec;
                end
                default: ;
            endcase
        end
    end

endmodule
